// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the shift-add multiplier sequencer.
package mult_ctrl_pkg;

  // Default operand width; also the number of add/shift iterations.
  localparam int MULT_WIDTH = 8;

  // Controller states, encoded compactly.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/multiplier_control.sv
// Sequencer for the signed shift-add multiplier: turns a Run rising edge into
// one clear, WIDTH conditional add / shift pairs (the last add subtracts for the
// sign bit), then holds the result until Run is released.
module multiplier_control
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic ClearAX,
  output logic Add_En,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             run_q;
  logic             start;
  logic             last_iter;

  // A multiply begins only on a fresh 0->1 of Run, so a held Run never restarts.
  assign start     = Run & ~run_q;
  assign last_iter = (cnt_q == CNT_LAST);

  // State register; reset drops straight to IDLE without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration counter and the one-cycle Run delay used for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= CNT_ZERO;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= Run;
    end
  end

  // Next-state and strobe decode; Add_En/Sub follow M live during ADD.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Clr_Ld   = 1'b0;
    ClearAX  = 1'b0;
    Add_En   = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Start wins over a simultaneous load request.
          state_d = CLR;
          cnt_d   = CNT_ZERO;
        end else begin
          Clr_Ld  = ClearA_LoadB;
        end
      end
      CLR: begin
        ClearAX = 1'b1;
        Busy    = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
        Add_En  = M;
        // The sign-bit weight is negative in two's complement, hence subtract.
        Sub     = M & last_iter;
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (last_iter) begin
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control (WIDTH=8). Inputs change 1 time unit
// after each rising edge; outputs are compared 2 units after the edge.
module tb_multiplier_control;
  import mult_ctrl_pkg::*;

  logic Clk;
  logic Reset_n;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_Ld;
  logic ClearAX;
  logic Add_En;
  logic Sub;
  logic Shift_En;
  logic Busy;
  logic Done;

  int tests_run;
  int tests_failed;

  multiplier_control #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .ClearAX      (ClearAX),
    .Add_En       (Add_En),
    .Sub          (Sub),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output bit order: {Clr_Ld, ClearAX, Add_En, Sub, Shift_En, Busy, Done}
  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_LOAD  = 7'b100_0000;
  localparam logic [6:0] O_CLR   = 7'b010_0010;
  localparam logic [6:0] O_ADD   = 7'b001_0010;
  localparam logic [6:0] O_SUB   = 7'b001_1010;
  localparam logic [6:0] O_NOADD = 7'b000_0010;
  localparam logic [6:0] O_SHIFT = 7'b000_0110;
  localparam logic [6:0] O_DONE  = 7'b000_0001;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {1'b0, Clr_Ld, ClearAX, Add_En, Sub, Shift_En, Busy, Done}, {1'b0, exp});
  endtask

  // Caller has raised Run in the current cycle; checks CLR, the 8 add/shift
  // pairs with M taken from mpat[i], and the first HOLD cycle.
  task automatic run_seq(input logic [7:0] mpat, input logic toggle_load, input string tag);
    logic [6:0] e;
    cyc();
    chk_out({tag, "_clr"}, O_CLR);
    for (int i = 0; i < 8; i++) begin
      cyc();
      M = mpat[i];
      if (toggle_load) ClearA_LoadB = ~ClearA_LoadB;
      if (mpat[i] && i == 7)      e = O_SUB;
      else if (mpat[i])           e = O_ADD;
      else                        e = O_NOADD;
      chk_out($sformatf("%s_add%0d", tag, i), e);
      cyc();
      if (toggle_load) ClearA_LoadB = ~ClearA_LoadB;
      chk_out($sformatf("%s_shift%0d", tag, i), O_SHIFT);
    end
    cyc();
    chk_out({tag, "_hold"}, O_DONE);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    Reset_n      = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    M            = 1'b0;

    // Reset state, before any clock edge.
    #2;
    chk_out("rst_outs", O_NONE);
    chk("rst_state", {5'd0, dut.state_q}, {5'd0, IDLE});
    ClearA_LoadB = 1'b1;
    chk_out("rst_load_follow", O_LOAD);
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc();
    chk_out("idle_quiet", O_NONE);

    // Load held for 3 cycles in IDLE.
    for (int i = 0; i < 3; i++) begin
      cyc();
      ClearA_LoadB = 1'b1;
      chk_out($sformatf("load%0d", i), O_LOAD);
    end
    cyc();
    ClearA_LoadB = 1'b0;
    chk_out("load_off", O_NONE);

    // Full multiply with M held 1; Run stays high into HOLD.
    cyc();
    Run = 1'b1;
    chk_out("start1_idle", O_NONE);
    run_seq(8'hFF, 1'b0, "m1");
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out($sformatf("hold_norestart%0d", i), O_DONE);
    end
    cyc();
    Run = 1'b0;
    chk_out("hold_run_low", O_DONE);
    cyc();
    chk_out("back_idle", O_NONE);
    chk("back_idle_state", {5'd0, dut.state_q}, {5'd0, IDLE});

    // Immediate restart, M held 0.
    Run = 1'b1;
    chk_out("restart_idle", O_NONE);
    run_seq(8'h00, 1'b0, "m0");
    cyc();
    Run = 1'b0;
    chk_out("m0_hold_drop", O_DONE);
    cyc();
    chk_out("m0_idle", O_NONE);

    // Run and load together: start wins; load toggling during Busy ignored.
    cyc();
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    chk_out("start_vs_load", O_NONE);
    run_seq(8'hA6, 1'b1, "mix");
    ClearA_LoadB = 1'b1;
    chk_out("hold_load_ignored", O_DONE);
    cyc();
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    chk_out("mix_hold_drop", O_DONE);
    cyc();
    chk_out("mix_idle", O_NONE);

    // Reset in SHIFT with cnt=3.
    cyc();
    Run = 1'b1;
    M   = 1'b1;
    cyc();
    chk_out("abort_clr", O_CLR);
    for (int i = 0; i < 8; i++) cyc();
    chk_out("abort_in_shift", O_SHIFT);
    chk("abort_cnt", {5'd0, dut.cnt_q}, 8'd3);
    Reset_n = 1'b0;
    Run     = 1'b0;
    chk_out("abort_outs", O_NONE);
    chk("abort_state", {5'd0, dut.state_q}, {5'd0, IDLE});
    chk("abort_cnt0", {5'd0, dut.cnt_q}, 8'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_out($sformatf("post_abort%0d", i), O_NONE);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multiplier_control.md
# multiplier_control

Sequencing controller for the 8-bit signed shift-add multiplier built around the 9-bit adder/subtractor. It converts a single Run request into the load/clear, conditional-add, final-subtract and arithmetic-shift strobes that drive the A/X/B register datapath. It then holds the result until Run is released.

## Interface
- WIDTH, 8, number of multiplier bits = number of add/shift iterations (≥2)
- Clk  in  1  system clock, all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  level request; a multiply starts on a sampled 0→1 transition
- ClearA_LoadB  in  1  level request; in IDLE, load B from switches and clear A and X
- M  in  1  current B[0] (multiplier LSB from datapath)
- Clr_Ld  out  1  load B, clear A and X
- ClearAX  out  1  clear A and X at the start of a multiply
- Add_En  out  1  load A and X from the adder output
- Sub  out  1  adder W input: 1 = subtract S
- Shift_En  out  1  arithmetic right shift of X:A:B
- Busy  out  1  high in CLR, ADD and SHIFT
- Done  out  1  high in HOLD

## Operation
- States are IDLE, CLR, ADD, SHIFT and HOLD. The iteration counter cnt has width $clog2(WIDTH).
- run_q register holds Run delayed by one cycle. start = Run & ~run_q.
- IDLE
  - If start: go to CLR and set cnt=0.
  - Otherwise, Clr_Ld = ClearA_LoadB, combinationally, for every cycle it is held.
  - start takes priority over ClearA_LoadB; Clr_Ld=0 on that cycle.
- CLR: ClearAX=1 for exactly one cycle, then go to ADD.
- ADD
  - Add_En=M.
  - Sub = M & (cnt==WIDTH-1). The sign-bit iteration subtracts.
  - Go to SHIFT.
- SHIFT
  - Shift_En=1.
  - If cnt==WIDTH-1: go to HOLD. Otherwise increment cnt and go to ADD.
- HOLD
  - Done=1.
  - When Run is sampled 0: go to IDLE.
  - Run held high never restarts a multiply, because start needs a new rising edge.
- Ignored inputs:
  - ClearA_LoadB is ignored outside IDLE.
  - Run deasserting during CLR/ADD/SHIFT is ignored; the sequence completes.
- Add_En and Sub are Mealy on M. All other outputs decode from state only.
- Sub is 0 whenever Add_En is 0.
- At most one of Clr_Ld, ClearAX, Add_En and Shift_En is high in any cycle.

## Timing
- Reset: Reset_n low forces the following immediately, without a clock edge:
  - state=IDLE, cnt=0, run_q=0
  - All outputs 0, except Clr_Ld, which follows ClearA_LoadB in IDLE.
- Reset mid-operation aborts with no further strobes. Datapath contents are undefined and not the controller's concern.
- Start latency: with Run=1 and run_q=0 sampled at edge n, CLR occupies cycle n+1.
- Sequence length:
  - ADD/SHIFT pairs occupy cycles n+2 … n+1+2·WIDTH.
  - For WIDTH=8, HOLD is entered at cycle n+18.
  - Busy is high for 1+2·WIDTH cycles.
- Exit latency: Run sampled 0 in HOLD at edge m puts IDLE in cycle m+1.
  - A new start is possible at edge m+1 at the earliest, if Run is high again there.
- Strobe order within one multiply:
  - exactly 1 ClearAX pulse
  - exactly WIDTH Shift_En pulses
  - Add_En pulses equal to the number of cycles M=1 was seen in ADD
  - each Add_En followed by exactly one Shift_En before the next ADD

## Structure
- Package mult_ctrl_pkg provides:
  - state enum typedef state_t {IDLE, CLR, ADD, SHIFT, HOLD}
  - localparam MULT_WIDTH=8, used as the WIDTH default
- Single module. Keep the edge detect and cnt inline; no sub-module is warranted.
- Two always_ff processes, both with asynchronous reset on negedge Reset_n:
  - state register
  - cnt and run_q
- One always_comb process for next-state and output decode.
- The datapath instantiates this block beside the 9-bit adder. The ninth adder bit feeds X.

## Test plan
- Reset mid-run: assert Reset_n=0 in SHIFT with cnt=3 → without a clock, all outputs drop to 0, Busy=0 and state=IDLE. After release, no strobes occur until a new Run edge.
- Load: ClearA_LoadB=1 for 3 cycles in IDLE with Run=0 → Clr_Ld=1 for exactly those 3 cycles, all other outputs 0.
- Full multiply with M held 1 and WIDTH=8, Run rising at edge n:
  - ClearAX in cycle n+1.
  - Add_En at n+2, n+4, … n+16, with Sub=1 only at n+16.
  - Shift_En at n+3 … n+17.
  - Done from n+18 until Run drops.
- M held 0 → zero Add_En pulses, 8 Shift_En pulses, Sub never 1, Done at n+18.
- Run held high past Done → no restart. Then drop Run for 1 cycle → IDLE. Raise Run again → a new CLR one cycle after the rising sample.
- Run and ClearA_LoadB rise on the same edge in IDLE → the sequence starts and Clr_Ld stays 0. Pulsing ClearA_LoadB during Busy → no Clr_Ld and an unchanged strobe sequence.
